patch_scheduler: RTL

Datapath-side responder to the convolution control sequencer. Consumes the sequencer's per-patch strobes (`addr`, `mux_sel`, `acc_enable`, `counter_enable`) and does three things:
- tracks the current output position of a K×K sliding window over an IMG_W×IMG_H feature map;
- generates the registered pixel-row read addresses and the result write address;
- raises `done`, which the sequencer samples in its CHECK_DONE state.

It sits between the control FSM and the image/result memories.

---
 rtl/patch_scheduler_if.sv | 29 ++
 rtl/patch_scheduler.sv | 117 +++++++++++
 2 files changed

// File: rtl/patch_scheduler_if.sv
// patch_scheduler_if: sequencer strobes in, memory addresses and status out.
//   master: sequencer/bench side (drives start, addr, mux_sel, acc_enable, counter_enable)
//   slave : patch_scheduler side (drives rd_addr, rd_en, wr_addr, wr_en, done, out_row, out_col)
interface patch_scheduler_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic              addr;
  logic [1:0]        mux_sel;
  logic              acc_enable;
  logic              counter_enable;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              done;
  logic [ADDR_W-1:0] out_row;
  logic [ADDR_W-1:0] out_col;

  modport master (
    output start, addr, mux_sel, acc_enable, counter_enable,
    input  rd_addr, rd_en, wr_addr, wr_en, done, out_row, out_col
  );

  modport slave (
    input  start, addr, mux_sel, acc_enable, counter_enable,
    output rd_addr, rd_en, wr_addr, wr_en, done, out_row, out_col
  );
endinterface

// File: rtl/patch_scheduler.sv
// patch_scheduler: tracks the sliding-window output position, generates pixel-row
// read addresses and result write addresses from the sequencer strobes, flags done.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of patch_scheduler_if (strobes in, addresses/status out)
module patch_scheduler #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  patch_scheduler_if.slave bus
);

  localparam int unsigned OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int unsigned OUT_H = (IMG_H - K) / STRIDE + 1;

  localparam logic [ADDR_W-1:0] ROW_PITCH  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(STRIDE * IMG_W);
  localparam logic [ADDR_W-1:0] COL_STEP   = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] OUT_W_A    = ADDR_W'(OUT_W);
  localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(OUT_H - 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_en_q, wr_en_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      row_q     <= '0;
      col_q     <= '0;
      base_q    <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      base_q    <= base_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
    end
  end

  // Next-state: start overrides everything; strobes only act in RUN
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    base_d    = base_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;

    if (bus.start) begin
      state_d = ST_RUN;
      row_d   = '0;
      col_d   = '0;
      base_d  = '0;
    end else if (state_q == ST_RUN) begin
      if (bus.addr) begin
        base_d = row_q * ROW_STEP + col_q * COL_STEP;
      end
      // Fetch uses the registered base, so an addr strobe lands one cycle ahead
      if (bus.mux_sel != 2'b00) begin
        rd_addr_d = base_q + ADDR_W'(bus.mux_sel - 2'd1) * ROW_PITCH;
        rd_en_d   = 1'b1;
      end
      // Write address always reflects the pre-advance position
      if (bus.acc_enable) begin
        wr_addr_d = row_q * OUT_W_A + col_q;
        wr_en_d   = 1'b1;
      end
      if (bus.counter_enable) begin
        if (row_q == LAST_ROW && col_q == LAST_COL) begin
          row_d   = '0;
          col_d   = '0;
          state_d = ST_DONE;
        end else if (col_q < LAST_COL) begin
          col_d = col_q + ADDR_W'(1);
        end else begin
          col_d = '0;
          row_d = row_q + ADDR_W'(1);
        end
      end
    end
  end

  assign bus.rd_addr = rd_addr_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.done    = (state_q == ST_DONE);
  assign bus.out_row = row_q;
  assign bus.out_col = col_q;

endmodule
